bresp_gen: RTL
==============

Name: bresp_gen

Overview:
- Generates the processor-side AXI B (write response) channel for the DRAM cache controller.
- Snoops accepted AW handshakes from the index extractor and queues their IDs in order.
- Consumes in-order write-commit pulses from the tag comparator (one per write whose data has been taken from the write buffer).
- Pairs each commit with the oldest queued ID and presents the response on bid/bvalid.
- Back-pressures AW acceptance through an almost-full flag.

Parameters:
ID_WIDTH, 4, width of AXI write ID
DEPTH, 16, ID queue entries (power of two, >= 4)
AFULL_THR, 14, queue occupancy at or above which afull_o asserts (< DEPTH)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
aw_fire_i  input  1  AW handshake completed this cycle (awvalid & awready)
awid_i  input  ID_WIDTH  ID of the accepted write; valid when aw_fire_i
wr_done_i  input  1  single-cycle pulse: oldest outstanding write committed by tag comparator
bid_o  output  ID_WIDTH  B response ID
bvalid_o  output  1  B response valid
bready_i  input  1  processor ready for B
afull_o  output  1  queue occupancy >= AFULL_THR; gate awready upstream
outstanding_o  output  $clog2(DEPTH)+1  queued IDs plus bvalid_o
err_o  output  1  sticky protocol error (overflow or unmatched commit)

Behaviour:
- The operative reset is synchronous: when rst=1 at a clk edge, all state clears. Reset overrides all inputs in that cycle, including mid-response, where a pending bvalid is dropped.
- Reset values: bvalid_o=0, bid_o=0, afull_o=0, outstanding_o=0, err_o=0. Queue pointers, occupancy and done_cnt all =0.
- ID queue: circular buffer with DEPTH entries, wr_ptr/rd_ptr of width $clog2(DEPTH), wrapping modulo DEPTH, plus an occ counter ($clog2(DEPTH)+1 bits).
- Push: on aw_fire_i, awid_i is written at wr_ptr. If occ==DEPTH with no same-cycle pop, the push is dropped and err_o is set.
- done_cnt ($clog2(DEPTH)+1 bits) counts commits not yet turned into responses.
  - wr_done_i is accepted only if done_cnt < occ (pre-edge values); then done_cnt increments.
  - Otherwise the pulse is dropped and err_o is set.
  - An AW must therefore precede its commit by >= 1 cycle.
- Output stage: a single register holding bid_o/bvalid_o.
  - load = (occ>0) & (done_cnt>0) & (!bvalid_o | bready_i).
  - On load: bid_o <= queue[rd_ptr], bvalid_o <= 1, rd_ptr++, occ--, done_cnt--.
  - If bvalid_o & bready_i & !load, then bvalid_o <= 0.
- Handshake: while bvalid_o=1 and bready_i=0, bid_o and bvalid_o hold stable. bvalid_o never depends combinationally on bready_i.
- Latency: with the ID already queued and the output idle, wr_done_i at cycle N gives bvalid_o=1 at cycle N+2 (counter at N+1, load at N+2 edge).
- Throughput: one response per cycle when bready_i is held high and credits are available (back-to-back load on handshake).
- Simultaneous events in one cycle:
  - Push + pop: occ unchanged, and a push into a full queue is allowed.
  - Commit increment + load decrement: done_cnt unchanged.
- afull_o = (occ >= AFULL_THR), registered from occ next-state.
- outstanding_o = occ + bvalid_o, combinational from registers.
- err_o stays set until reset; no other effect on operation.
- Responses are strictly in AW order. IDs are not reordered or interpreted.

Test Plan:
- Reset sequence: hold rst=1 3 cycles with aw_fire_i=1 -> bvalid_o=0, outstanding_o=0, afull_o=0, err_o=0 after release.
- Single write: aw_fire_i with awid_i=0x5 at cycle 0, wr_done_i at cycle 3, bready_i=1 -> bvalid_o=1, bid_o=0x5 exactly at cycle 5 for one cycle; outstanding_o returns 0.
- Back-to-back ordering: IDs 1,2,3 pushed on consecutive cycles, three consecutive wr_done_i, bready_i=1 -> bid_o 1,2,3 on three consecutive cycles, no bubbles.
- Backpressure: two commits queued, bready_i=0 for 4 cycles -> bid_o stays at the first ID with bvalid_o=1. Release bready -> second ID on the following cycle.
- Full/afull boundary, DEPTH=16, AFULL_THR=14:
  - 14 pushes -> afull_o=1.
  - 16 pushes -> a 17th push sets err_o and is dropped.
  - 16 commits then yield exactly IDs 0..15 in order, and the pointers wrap correctly on a further 4 push/commit rounds.
- Unmatched commit: wr_done_i with occ=0 -> err_o=1, done_cnt stays 0, no bvalid_o. A later push plus commit still produces a correct response.

Source files
------------

// File: rtl/bresp_gen.sv
// bresp_gen: AXI B-channel generator. Queues accepted AW IDs in order and
// releases one response per in-order write-commit pulse.
`default_nettype none

module bresp_gen #(
  parameter int ID_WIDTH  = 4,
  parameter int DEPTH     = 16,
  parameter int AFULL_THR = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      aw_fire_i,
  input  logic [ID_WIDTH-1:0]       awid_i,
  input  logic                      wr_done_i,
  output logic [ID_WIDTH-1:0]       bid_o,
  output logic                      bvalid_o,
  input  logic                      bready_i,
  output logic                      afull_o,
  output logic [$clog2(DEPTH):0]    outstanding_o,
  output logic                      err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ID_WIDTH-1:0] id_mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       occ;
  logic [CW-1:0]       occ_nxt;
  logic [CW-1:0]       done_cnt;
  logic                load;
  logic                push_ok;
  logic                commit_ok;

  // A same-cycle pop frees the slot, so a full queue may still accept a push.
  assign load      = (occ != '0) && (done_cnt != '0) && (!bvalid_o || bready_i);
  assign push_ok   = aw_fire_i && ((occ != CW'(DEPTH)) || load);
  assign commit_ok = wr_done_i && (done_cnt < occ);
  assign occ_nxt   = occ + CW'(push_ok) - CW'(load);

  assign outstanding_o = occ + CW'(bvalid_o);

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      id_mem[wr_ptr] <= awid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      done_cnt <= '0;
      bid_o    <= '0;
      bvalid_o <= 1'b0;
      afull_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      done_cnt <= done_cnt + CW'(commit_ok) - CW'(load);
      afull_o  <= (occ_nxt >= CW'(AFULL_THR));
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (load) begin
        bid_o    <= id_mem[rd_ptr];
        bvalid_o <= 1'b1;
        rd_ptr   <= rd_ptr + PW'(1);
      end else if (bready_i) begin
        bvalid_o <= 1'b0;
      end
      if ((aw_fire_i && !push_ok) || (wr_done_i && !commit_ok)) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
